seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder_pkg.sv | 31 +++
 rtl/seq_chunk_adder_if.sv | 26 ++
 rtl/seq_chunk_adder_rca.sv | 30 +++
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 tb/tb_seq_chunk_adder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder family.
// Holds the FSM state encoding, chunk-count arithmetic and the full-adder cell.
package seq_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of chunk steps needed to cover the operand width.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk-index register width; kept at one bit even for a single chunk.
    function automatic int calc_idx_w(input int nch);
        int w;
        w = $clog2(nch);
        return (w < 1) ? 1 : w;
    endfunction

    // One full-adder cell, returned as {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s_bit;
        logic c_bit;
        s_bit = x ^ y ^ ci;
        c_bit = (x & y) | (ci & (x ^ y));
        return {c_bit, s_bit};
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle between a client and seq_chunk_adder.
// The client side drives the operands and start; the adder returns status and result.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  ready, s, cout, ovf, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, s, cout, ovf, done
    );
endinterface

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry adder made of full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_rca
    import seq_adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic [1:0] fa_s;
        assign fa_s     = full_add(x[i], y[i], c_s[i]);
        assign sum[i]   = fa_s[0];
        assign c_s[i+1] = fa_s[1];
    end

    assign co       = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through one registered carry.
// Start/ready/done handshake, subtract mode and signed-overflow flag.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_chunk_adder_if.slave   bus
);

    localparam int NCH   = calc_nch(WIDTH, CHUNK);
    localparam int IDX_W = calc_idx_w(NCH);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NCH - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be an integer multiple of CHUNK");
    end

    state_t                       state_r;
    logic [NCH-1:0][CHUNK-1:0]    a_r;
    logic [NCH-1:0][CHUNK-1:0]    b_r;
    logic [NCH-1:0][CHUNK-1:0]    s_r;
    logic [IDX_W-1:0]             k_r;
    logic                         carry_r;
    logic                         cout_r;
    logic                         ovf_r;
    logic                         done_r;
    logic                         ready_r;

    logic [CHUNK-1:0]             x_s;
    logic [CHUNK-1:0]             y_s;
    logic [CHUNK-1:0]             sum_s;
    logic                         co_s;
    logic                         cmsb_s;

    // b is stored pre-inverted for subtract, so the datapath only ever adds.
    assign x_s = a_r[k_r];
    assign y_s = b_r[k_r];

    chunk_rca #(
        .CHUNK (CHUNK)
    ) u_rca (
        .x        (x_s),
        .y        (y_s),
        .ci       (carry_r),
        .sum      (sum_s),
        .co       (co_s),
        .c_msb_in (cmsb_s)
    );

    // Handshake FSM, operand capture and chunk-by-chunk result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            k_r     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_r <= bus.sub ? 1'b1 : bus.cin;
                        k_r     <= '0;
                        ready_r <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    s_r[k_r] <= sum_s;
                    carry_r  <= co_s;
                    if (k_r == K_LAST) begin
                        cout_r  <= co_s;
                        ovf_r   <= co_s ^ cmsb_s;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        k_r     <= '0;
                        state_r <= IDLE;
                    end else begin
                        k_r <= k_r + IDX_W'(1);
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    k_r     <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.s     = s_r;
    assign bus.cout  = cout_r;
    assign bus.ovf   = ovf_r;
    assign bus.done  = done_r;
    assign bus.ready = ready_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder at WIDTH=32, CHUNK=8.
module tb_seq_chunk_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[12];

    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

    seq_chunk_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            cyc = i + 1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc;
        bit   seen;
        v = vecs[idx];
        @(negedge clk);
        check_val($sformatf("v%0d_ready_idle", idx), bus.ready, 1);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.cin   = v.cin;
        bus.sub   = v.sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check_val($sformatf("v%0d_ready_busy", idx), bus.ready, 0);
        wait_done(cyc, seen);
        check_val($sformatf("v%0d_done_seen", idx), seen, 1);
        check_val($sformatf("v%0d_latency", idx), cyc, NCH);
        check_val($sformatf("v%0d_ready_done", idx), bus.ready, 1);
        check_val($sformatf("v%0d_s", idx), bus.s, v.s);
        check_val($sformatf("v%0d_cout", idx), bus.cout, v.cout);
        check_val($sformatf("v%0d_ovf", idx), bus.ovf, v.ovf);
        @(posedge clk);
        #1;
        check_val($sformatf("v%0d_done_1cyc", idx), bus.done, 0);
        check_val($sformatf("v%0d_s_hold", idx), bus.s, v.s);
    endtask

    initial begin
        int cyc;
        bit seen;
        bit extra;
        bit first;

        vecs[0]  = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000E, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[7]  = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 32'h0000_2345, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        rst       = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_val("rst_ready", bus.ready, 1);
        check_val("rst_done", bus.done, 0);
        check_val("rst_s", bus.s, 0);
        check_val("rst_cout", bus.cout, 0);
        check_val("rst_ovf", bus.ovf, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed arithmetic vectors, one operation at a time
        for (int i = 0; i < 11; i++) run_vec(i);

        // Start while busy must be ignored
        @(negedge clk);
        bus.a = 32'd100; bus.b = 32'd23; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.a = 32'd1; bus.b = 32'd1; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(cyc, seen);
        check_val("busy_done_seen", seen, 1);
        check_val("busy_latency", cyc, 1);
        check_val("busy_s", bus.s, 32'd123);
        extra = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra = 1'b1;
        end
        check_val("busy_no_extra_done", extra, 0);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.a = 32'h0000_1234; bus.b = 32'h0000_1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_ready", bus.ready, 1);
        check_val("midrst_s", bus.s, 0);
        check_val("midrst_done", bus.done, 0);
        check_val("midrst_cout", bus.cout, 0);
        check_val("midrst_ovf", bus.ovf, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        extra = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra = 1'b1;
        end
        check_val("midrst_no_done", extra, 0);
        run_vec(11);

        // Back-to-back sweep with start held high
        first = 1'b1;
        for (int ia = 2; ia <= 18; ia++) begin
            for (int ib = 2; ib <= 18; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    bus.a     = 32'(ia);
                    bus.b     = 32'(ib);
                    bus.cin   = 1'(ic);
                    bus.sub   = 1'b0;
                    bus.start = 1'b1;
                    if (first) begin
                        @(posedge clk);
                        #1;
                    end
                    wait_done(cyc, seen);
                    check_val("sweep_done_seen", seen, 1);
                    check_val("sweep_gap", cyc, first ? NCH : NCH + 1);
                    check_val("sweep_s", bus.s, ia + ib + ic);
                    check_val("sweep_cout", bus.cout, 0);
                    first = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
